// File: rtl/conway_window_gen_pkg.sv
// conway_pkg: shared constants for the Conway 3x3 window generator.
//   NBR_A..NBR_H : bit positions of the eight neighbours inside out_nbr
//                  ({A..H} = {NW,N,NE,W,E,SW,S,SE}, A in bit 7)
//   LOAD_FIRST/LOAD/EMIT/EMIT_LAST : FSM state encoding
//   DEF_GRID_W/DEF_GRID_H          : default grid size
package conway_pkg;
  localparam int NBR_A = 7;
  localparam int NBR_B = 6;
  localparam int NBR_C = 5;
  localparam int NBR_D = 4;
  localparam int NBR_E = 3;
  localparam int NBR_F = 2;
  localparam int NBR_G = 1;
  localparam int NBR_H = 0;

  localparam logic [1:0] LOAD_FIRST = 2'd0;
  localparam logic [1:0] LOAD       = 2'd1;
  localparam logic [1:0] EMIT       = 2'd2;
  localparam logic [1:0] EMIT_LAST  = 2'd3;

  localparam int DEF_GRID_W = 16;
  localparam int DEF_GRID_H = 16;
endpackage

// File: rtl/conway_window_gen_if.sv
// conway_window_gen_if: cell-stream input and window output of the generator.
//   in_valid/in_ready/in_cell          : raster-order cell stream
//   out_valid/out_ready                : window handshake
//   out_nbr/out_self/out_row/out_col/out_last : window payload
// Modports: slave = generator side, master = producer/consumer environment.
interface conway_window_gen_if
  import conway_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H
);
  localparam int COL_W = $clog2(GRID_W);
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  logic             in_valid;
  logic             in_ready;
  logic             in_cell;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_nbr;
  logic             out_self;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_last;

  modport slave (
    input  in_valid, in_cell, out_ready,
    output in_ready, out_valid, out_nbr, out_self, out_row, out_col, out_last
  );

  modport master (
    output in_valid, in_cell, out_ready,
    input  in_ready, out_valid, out_nbr, out_self, out_row, out_col, out_last
  );
endinterface

// File: rtl/conway_window_gen_row_shift.sv
// conway_row_shift: serial-in row register with beat counter.
//   clk, rst  : clock, synchronous active-high reset
//   shift_en  : accept bit_in this cycle
//   bit_in    : incoming cell, column order 0..GRID_W-1
//   row_full  : complete row including bit_in (meaningful when row_done)
//   row_done  : this beat completes a row
module conway_row_shift #(
  parameter int GRID_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [GRID_W-1:0] row_full,
  output logic              row_done
);
  localparam int CNT_W = $clog2(GRID_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(GRID_W - 1);

  // Cells enter at the top and move down, so column 0 ends in bit 0.
  logic [GRID_W-2:0] shreg;
  logic [CNT_W-1:0]  beat;

  assign row_full = {bit_in, shreg};
  assign row_done = shift_en && (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      beat  <= '0;
    end else if (shift_en) begin
      shreg <= row_full[GRID_W-1:1];
      beat  <= row_done ? '0 : beat + 1'b1;
    end
  end
endmodule

// File: rtl/conway_window_gen.sv
// conway_window_gen: buffers three rows of a raster cell stream and emits one
// registered 3x3 neighbourhood per cell in raster order, dead padding at edges.
//   clk, rst : clock, synchronous active-high reset
//   bus      : conway_window_gen_if.slave (cell stream in, windows out)
//   pop_count/pop_valid : only with ALIVE_COUNT_EN defined; alive-cell count of
//                         the frame, pulsed after the final input beat.
module conway_window_gen
  import conway_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H
) (
  input  logic clk,
  input  logic rst,
  conway_window_gen_if.slave bus
`ifdef ALIVE_COUNT_EN
  ,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0] pop_count,
  output logic                               pop_valid
`endif
);
  localparam int COL_W = $clog2(GRID_W);
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);

  logic [1:0]        state;
  logic [ROW_W-1:0]  r, r_nx;
  logic [GRID_W-1:0] prev_row, cur_row, nxt_row, row_full;
  logic              row_done, in_fire, out_fire;
  logic [COL_W-1:0]  col_nx;

  logic              in_ready_q, out_valid_q, out_self_q, out_last_q;
  logic [7:0]        out_nbr_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign r_nx     = r + 1'b1;
  assign col_nx   = out_col_q + 1'b1;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_nbr   = out_nbr_q;
  assign bus.out_self  = out_self_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;

  conway_row_shift #(.GRID_W(GRID_W)) u_row_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_fire),
    .bit_in   (bus.in_cell),
    .row_full (row_full),
    .row_done (row_done)
  );

  // Returns {nbr[7:0], self}. Rows are padded with a dead cell on each side so
  // a 3-bit slice starting at col always holds {col+1, col, col-1}.
  function automatic logic [8:0] window(input logic [GRID_W-1:0] p,
                                        input logic [GRID_W-1:0] c,
                                        input logic [GRID_W-1:0] n,
                                        input logic [COL_W-1:0]  col);
    logic [2:0] pw, cw, nw;
    logic [7:0] nbr;
    pw = 3'({1'b0, p, 1'b0} >> col);
    cw = 3'({1'b0, c, 1'b0} >> col);
    nw = 3'({1'b0, n, 1'b0} >> col);
    nbr = '0;
    nbr[NBR_A] = pw[0];
    nbr[NBR_B] = pw[1];
    nbr[NBR_C] = pw[2];
    nbr[NBR_D] = cw[0];
    nbr[NBR_E] = cw[2];
    nbr[NBR_F] = nw[0];
    nbr[NBR_G] = nw[1];
    nbr[NBR_H] = nw[2];
    return {nbr, cw[1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_FIRST;
      r           <= '0;
      prev_row    <= '0;
      cur_row     <= '0;
      nxt_row     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_nbr_q   <= '0;
      out_self_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        LOAD_FIRST: begin
          in_ready_q <= 1'b1;
          if (row_done) begin
            prev_row <= '0;
            cur_row  <= row_full;
            if (GRID_H == 1) begin
              // Single-row frame: emit straight away with dead rows above/below.
              nxt_row                 <= '0;
              state                   <= EMIT_LAST;
              in_ready_q              <= 1'b0;
              {out_nbr_q, out_self_q} <= window('0, row_full, '0, '0);
              out_valid_q             <= 1'b1;
              out_row_q               <= '0;
              out_col_q               <= '0;
              out_last_q              <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (row_done) begin
            nxt_row                 <= row_full;
            state                   <= EMIT;
            in_ready_q              <= 1'b0;
            {out_nbr_q, out_self_q} <= window(prev_row, cur_row, row_full, '0);
            out_valid_q             <= 1'b1;
            out_row_q               <= r;
            out_col_q               <= '0;
            out_last_q              <= 1'b0;
          end
        end
        EMIT, EMIT_LAST: begin
          if (out_fire) begin
            if (out_col_q != LAST_COL) begin
              {out_nbr_q, out_self_q} <= window(prev_row, cur_row, nxt_row, col_nx);
              out_col_q               <= col_nx;
              out_last_q              <= (state == EMIT_LAST) && (col_nx == LAST_COL);
            end else if (state == EMIT) begin
              prev_row <= cur_row;
              cur_row  <= nxt_row;
              r        <= r_nx;
              if (r_nx == LAST_ROW) begin
                // Last row is already buffered: start its windows without a gap.
                nxt_row                 <= '0;
                state                   <= EMIT_LAST;
                {out_nbr_q, out_self_q} <= window(cur_row, nxt_row, '0, '0);
                out_row_q               <= r_nx;
                out_col_q               <= '0;
                out_last_q              <= 1'b0;
              end else begin
                state       <= LOAD;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
              end
            end else begin
              state       <= LOAD_FIRST;
              r           <= '0;
              prev_row    <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
            end
          end
        end
        default: state <= LOAD_FIRST;
      endcase
    end
  end

`ifdef ALIVE_COUNT_EN
  localparam int POP_W = $clog2(GRID_W*GRID_H+1);
  logic [POP_W-1:0] pop_acc;
  logic             frame_end;

  // The final beat of a frame completes row H-1.
  assign frame_end = row_done &&
                     (((state == LOAD_FIRST) && (GRID_H == 1)) ||
                      ((state == LOAD) && (r_nx == LAST_ROW)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_acc   <= '0;
      pop_count <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      pop_count <= '0;
      if (in_fire) begin
        if (frame_end) begin
          pop_count <= pop_acc + POP_W'(bus.in_cell);
          pop_valid <= 1'b1;
          pop_acc   <= '0;
        end else begin
          pop_acc <= pop_acc + POP_W'(bus.in_cell);
        end
      end
    end
  end
`endif
endmodule
